// File: rtl/dram_refresh_ctl.sv
// dram_refresh_ctl: FPM/EDO DRAM sequencer for the 68000 bus. It multiplexes
// row/column addresses, drives RAS/CAS/WE/OE and the bus Ready qualifier, and
// runs CAS-before-RAS refresh from an internal interval timer with a
// saturating backlog that preempts CPU accesses once it becomes urgent.
module dram_refresh_ctl #(
  parameter int RA_W         = 10,
  parameter int TRCD         = 2,
  parameter int TCAS         = 2,
  parameter int TRP          = 2,
  parameter int TREF         = 3,
  parameter int REF_INTERVAL = 120,
  parameter int MAX_PEND     = 4,
  parameter int URGENT       = 3
) (
  input  logic                           CLK,
  input  logic                           nRESET,
  input  logic [2*RA_W:1]                A,
  input  logic                           nAS,
  input  logic                           nWE,
  input  logic                           nLDS,
  input  logic                           nUDS,
  input  logic                           RAMCS,
  input  logic                           ASActive,
  input  logic                           ASInactive,
  output logic                           Ready,
  output logic [RA_W-1:0]                RA,
  output logic                           nRAS,
  output logic                           nCAS,
  output logic                           nLWE,
  output logic                           nUWE,
  output logic                           nOE,
  output logic [$clog2(MAX_PEND+1)-1:0]  RefPending,
  output logic                           RefOverrun
);

  localparam int PW    = $clog2(MAX_PEND + 1);
  localparam int MAXA  = (TRCD > TCAS) ? TRCD : TCAS;
  localparam int MAXB  = (TRP > TREF) ? TRP : TREF;
  localparam int MAXT  = (MAXA > MAXB) ? MAXA : MAXB;
  localparam int CW    = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int IW    = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RAS, S_CAS, S_HOLD, S_PRE, S_RCAS, S_RRAS
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  timer_q, timer_d;
  logic [IW-1:0]  intervalCnt_q, intervalCnt_d;
  logic [PW-1:0]  pending_q, pending_d;
  logic           overrun_q, overrun_d;
  logic           nRas_q, nRas_d;
  logic           nCas_q, nCas_d;
  logic           ready_q, ready_d;
  logic           tick;
  logic           takeRefresh;
  logic           accessReq;
  logic           isColumn;
  logic           isAccess;

  assign accessReq = ASActive & RAMCS;

  // Refresh interval down-counter: one tick each time it wraps through zero.
  always_comb begin
    tick          = (intervalCnt_q == '0);
    intervalCnt_d = tick ? IW'(REF_INTERVAL - 1) : intervalCnt_q - IW'(1);
  end

  // Sequencer next state; strobes and ready are registered from the next state.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    takeRefresh = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pending_q >= PW'(URGENT)) begin
          state_d     = S_RCAS;
          takeRefresh = 1'b1;
        end else if (accessReq) begin
          state_d = S_RAS;
          timer_d = CW'(TRCD - 1);
        end else if (pending_q != '0) begin
          state_d     = S_RCAS;
          takeRefresh = 1'b1;
        end
      end
      S_RAS: begin
        if (timer_q == '0) begin
          state_d = S_CAS;
          timer_d = CW'(TCAS - 1);
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end
      S_CAS: begin
        if (timer_q == '0) state_d = S_HOLD;
        else               timer_d = timer_q - CW'(1);
      end
      S_HOLD: begin
        if (ASInactive) begin
          state_d = S_PRE;
          timer_d = CW'(TRP - 1);
        end
      end
      S_PRE: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - CW'(1);
      end
      S_RCAS: begin
        state_d = S_RRAS;
        timer_d = CW'(TREF - 1);
      end
      S_RRAS: begin
        if (timer_q == '0) begin
          state_d = S_PRE;
          timer_d = CW'(TRP - 1);
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    nRas_d  = !(state_d inside {S_RAS, S_CAS, S_HOLD, S_RRAS});
    nCas_d  = !(state_d inside {S_CAS, S_HOLD, S_RCAS, S_RRAS});
    ready_d = (state_d == S_HOLD);
  end

  // Backlog: a tick that coincides with a refresh start takes the freed slot.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (tick && !takeRefresh) begin
      if (pending_q == PW'(MAX_PEND)) overrun_d = 1'b1;
      else                            pending_d = pending_q + PW'(1);
    end else if (takeRefresh && !tick) begin
      pending_d = pending_q - PW'(1);
    end
  end

  // State, timers and registered strobes; reset forces every strobe high.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q       <= S_IDLE;
      timer_q       <= '0;
      intervalCnt_q <= IW'(REF_INTERVAL - 1);
      pending_q     <= '0;
      overrun_q     <= 1'b0;
      nRas_q        <= 1'b1;
      nCas_q        <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      intervalCnt_q <= intervalCnt_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      nRas_q        <= nRas_d;
      nCas_q        <= nCas_d;
      ready_q       <= ready_d;
    end
  end

  // Address mux and the state-qualified enables follow the current state.
  assign isColumn   = (state_q == S_CAS) || (state_q == S_HOLD);
  assign isAccess   = (state_q == S_RAS) || isColumn;
  assign RA         = isColumn ? A[RA_W:1] : A[2*RA_W:RA_W+1];
  assign nRAS       = nRas_q;
  assign nCAS       = nCas_q;
  assign Ready      = ~RAMCS | ready_q;
  assign nOE        = ~(~nAS & nWE & (~nLDS | ~nUDS) & RAMCS & isColumn);
  assign nLWE       = ~(~nAS & ~nWE & ~nLDS & isAccess);
  assign nUWE       = ~(~nAS & ~nWE & ~nUDS & isAccess);
  assign RefPending = pending_q;
  assign RefOverrun = overrun_q;

endmodule

// File: tb/tb_dram_refresh_ctl.sv
// tb_dram_refresh_ctl: directed scenarios with literal expectations followed
// by randomized bus traffic, all compared every cycle against a timeline
// model of the controller (access age, refresh age, backlog arithmetic).
module tb_dram_refresh_ctl;

  localparam int RA_W         = 10;
  localparam int TRCD         = 2;
  localparam int TCAS         = 2;
  localparam int TRP          = 2;
  localparam int TREF         = 3;
  localparam int REF_INTERVAL = 120;
  localparam int MAX_PEND     = 4;
  localparam int URGENT       = 3;

  logic              CLK = 1'b0;
  logic              nRESET = 1'b0;
  logic [2*RA_W:1]   A = '0;
  logic              nAS = 1'b1;
  logic              nWE = 1'b1;
  logic              nLDS = 1'b1;
  logic              nUDS = 1'b1;
  logic              RAMCS = 1'b0;
  logic              ASActive = 1'b0;
  logic              ASInactive = 1'b1;
  logic              Ready;
  logic [RA_W-1:0]   RA;
  logic              nRAS;
  logic              nCAS;
  logic              nLWE;
  logic              nUWE;
  logic              nOE;
  logic [2:0]        RefPending;
  logic              RefOverrun;

  int checksTotal  = 0;
  int checksPassed = 0;

  // Model: kind 0 = free, 1 = access, 2 = refresh, 3 = precharge.
  int mKind    = 0;
  int mAge     = 0;
  int mToTick  = REF_INTERVAL - 1;
  int mPend    = 0;
  bit mOverrun = 1'b0;

  bit expCol;
  bit expRasLow;
  bit expCasLow;
  bit expReady;
  bit expAccess;

  dram_refresh_ctl #(
    .RA_W(RA_W), .TRCD(TRCD), .TCAS(TCAS), .TRP(TRP), .TREF(TREF),
    .REF_INTERVAL(REF_INTERVAL), .MAX_PEND(MAX_PEND), .URGENT(URGENT)
  ) dut (
    .CLK(CLK), .nRESET(nRESET), .A(A), .nAS(nAS), .nWE(nWE), .nLDS(nLDS),
    .nUDS(nUDS), .RAMCS(RAMCS), .ASActive(ASActive), .ASInactive(ASInactive),
    .Ready(Ready), .RA(RA), .nRAS(nRAS), .nCAS(nCAS), .nLWE(nLWE),
    .nUWE(nUWE), .nOE(nOE), .RefPending(RefPending), .RefOverrun(RefOverrun)
  );

  // 10-unit bus clock.
  initial forever #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksTotal++;
    if (actual !== expected)
      $display("[TB] FAIL %s at %0t: actual %0h, expected %0h", name, $time, actual, expected);
    else
      checksPassed++;
  endtask

  task automatic applyStimulus(input bit asAct, input bit nasPin, input bit ramcs,
                               input bit nwe, input bit nlds, input bit nuds,
                               input logic [2*RA_W:1] addr);
    ASActive   = asAct;
    ASInactive = !asAct;
    nAS        = nasPin;
    RAMCS      = ramcs;
    nWE        = nwe;
    nLDS       = nlds;
    nUDS       = nuds;
    A          = addr;
  endtask

  task automatic stepEdges(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Leaves the bus idle and releases reset between edges; the next edge is E0.
  task automatic doReset();
    @(negedge CLK);
    #3;
    nRESET = 1'b0;
    applyStimulus(0, 1, 0, 1, 1, 1, '0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #2;
    nRESET = 1'b1;
  endtask

  task automatic modelReset();
    mKind    = 0;
    mAge     = 0;
    mToTick  = REF_INTERVAL - 1;
    mPend    = 0;
    mOverrun = 1'b0;
  endtask

  // One clock edge of the model, using the inputs as sampled at that edge.
  task automatic modelStep();
    bit tickNow;
    bit take;
    bit req;
    tickNow = (mToTick == 0);
    mToTick = tickNow ? REF_INTERVAL - 1 : mToTick - 1;
    req     = ASActive && RAMCS;
    take    = 1'b0;
    case (mKind)
      0: begin
        if (mPend >= URGENT || (!req && mPend > 0)) begin
          mKind = 2; mAge = 0; take = 1'b1;
        end else if (req) begin
          mKind = 1; mAge = 0;
        end
      end
      1: begin
        if (mAge == TRCD + TCAS) begin
          if (ASInactive) begin mKind = 3; mAge = 0; end
        end else begin
          mAge++;
        end
      end
      2: begin
        if (mAge == TREF) begin mKind = 3; mAge = 0; end
        else mAge++;
      end
      default: begin
        if (mAge == TRP - 1) begin mKind = 0; mAge = 0; end
        else mAge++;
      end
    endcase
    if (tickNow && !take) begin
      if (mPend == MAX_PEND) mOverrun = 1'b1;
      else mPend++;
    end else if (take && !tickNow) begin
      mPend--;
    end
  endtask

  // Model process: async reset or one step per rising edge.
  initial begin
    forever begin
      @(posedge CLK or negedge nRESET);
      if (!nRESET) modelReset();
      else modelStep();
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge CLK);
      expAccess = (mKind == 1);
      expCol    = expAccess && (mAge >= TRCD);
      expRasLow = expAccess || (mKind == 2 && mAge >= 1);
      expCasLow = expCol || (mKind == 2);
      expReady  = expAccess && (mAge == TRCD + TCAS);
      checkOutput("model nRAS", nRAS, !expRasLow);
      checkOutput("model nCAS", nCAS, !expCasLow);
      checkOutput("model Ready", Ready, !RAMCS || expReady);
      checkOutput("model RA", RA, expCol ? A[RA_W:1] : A[2*RA_W:RA_W+1]);
      checkOutput("model nOE", nOE, !(!nAS && nWE && (!nLDS || !nUDS) && RAMCS && expCol));
      checkOutput("model nLWE", nLWE, !(!nAS && !nWE && !nLDS && expAccess));
      checkOutput("model nUWE", nUWE, !(!nAS && !nWE && !nUDS && expAccess));
      checkOutput("model RefPending", RefPending, mPend);
      checkOutput("model RefOverrun", RefOverrun, mOverrun);
    end
  end

  // Directed scenarios with literal expectations, then randomized traffic.
  initial begin
    int gap;
    int len;

    // Reset state.
    doReset();
    RAMCS = 1'b1;
    #1;
    checkOutput("reset nRAS", nRAS, 1);
    checkOutput("reset nCAS", nCAS, 1);
    checkOutput("reset Ready", Ready, 0);
    checkOutput("reset RefPending", RefPending, 0);
    checkOutput("reset nOE", nOE, 1);

    // Read access with default timing.
    doReset();
    applyStimulus(1, 0, 1, 1, 0, 0, {10'h2A5, 10'h13C});
    stepEdges(1);
    checkOutput("read E0 nRAS", nRAS, 0);
    checkOutput("read E0 nCAS", nCAS, 1);
    checkOutput("read E0 RA row", RA, 10'h2A5);
    stepEdges(1);
    checkOutput("read E1 nCAS", nCAS, 1);
    checkOutput("read E1 RA row", RA, 10'h2A5);
    stepEdges(1);
    checkOutput("read E2 nCAS", nCAS, 0);
    checkOutput("read E2 RA col", RA, 10'h13C);
    checkOutput("read E2 nOE", nOE, 0);
    stepEdges(1);
    checkOutput("read E3 Ready", Ready, 0);
    stepEdges(1);
    checkOutput("read E4 Ready", Ready, 1);
    stepEdges(2);
    applyStimulus(0, 1, 1, 1, 0, 0, {10'h2A5, 10'h13C});
    stepEdges(1);
    checkOutput("read E7 nRAS", nRAS, 1);
    checkOutput("read E7 nCAS", nCAS, 1);
    checkOutput("read E7 Ready", Ready, 0);
    applyStimulus(1, 0, 1, 1, 0, 0, {10'h0F1, 10'h00E});
    stepEdges(2);
    checkOutput("read E9 still precharge", nRAS, 1);
    stepEdges(1);
    checkOutput("read E10 new RAS", nRAS, 0);

    // Lower-byte write.
    doReset();
    applyStimulus(1, 0, 1, 0, 0, 1, {10'h155, 10'h0AA});
    #1;
    checkOutput("write idle nLWE", nLWE, 1);
    stepEdges(1);
    checkOutput("write E0 nLWE", nLWE, 0);
    checkOutput("write E0 nUWE", nUWE, 1);
    stepEdges(4);
    checkOutput("write E4 nLWE", nLWE, 0);
    checkOutput("write E4 nOE", nOE, 1);
    stepEdges(2);
    applyStimulus(0, 0, 1, 0, 0, 1, {10'h155, 10'h0AA});
    #1;
    checkOutput("write E6 nLWE", nLWE, 0);
    stepEdges(1);
    checkOutput("write E7 nLWE", nLWE, 1);
    applyStimulus(0, 1, 0, 1, 1, 1, '0);

    // Idle refresh after one interval.
    doReset();
    stepEdges(119);
    checkOutput("idle 119 RefPending", RefPending, 0);
    stepEdges(1);
    checkOutput("idle 120 RefPending", RefPending, 1);
    checkOutput("idle 120 nCAS", nCAS, 1);
    stepEdges(1);
    checkOutput("idle RCAS nCAS", nCAS, 0);
    checkOutput("idle RCAS nRAS", nRAS, 1);
    checkOutput("idle RCAS RefPending", RefPending, 0);
    stepEdges(1);
    checkOutput("idle RRAS1 nRAS", nRAS, 0);
    stepEdges(2);
    checkOutput("idle RRAS3 nRAS", nRAS, 0);
    stepEdges(1);
    checkOutput("idle PRE nRAS", nRAS, 1);
    checkOutput("idle PRE nCAS", nCAS, 1);

    // Urgent preemption: three ticks accrue while an access is held.
    doReset();
    applyStimulus(1, 0, 1, 1, 0, 0, {10'h011, 10'h022});
    stepEdges(365);
    checkOutput("urgent backlog", RefPending, 3);
    applyStimulus(0, 1, 1, 1, 0, 0, {10'h011, 10'h022});
    stepEdges(1);
    applyStimulus(1, 0, 1, 1, 0, 0, {10'h033, 10'h044});
    stepEdges(3);
    checkOutput("urgent RCAS nCAS", nCAS, 0);
    checkOutput("urgent RCAS nRAS", nRAS, 1);
    checkOutput("urgent RCAS Ready", Ready, 0);
    checkOutput("urgent RCAS RefPending", RefPending, 2);
    stepEdges(3);
    checkOutput("urgent RRAS Ready", Ready, 0);
    stepEdges(4);
    checkOutput("urgent access nRAS", nRAS, 0);
    checkOutput("urgent access nCAS", nCAS, 1);
    checkOutput("urgent access RA", RA, 10'h033);
    stepEdges(4);
    checkOutput("urgent access Ready", Ready, 1);
    checkOutput("urgent after RefPending", RefPending, 2);
    applyStimulus(0, 1, 0, 1, 1, 1, '0);
    stepEdges(20);

    // Saturation and sticky overrun.
    doReset();
    applyStimulus(1, 0, 1, 1, 0, 0, {10'h3FF, 10'h200});
    stepEdges(485);
    checkOutput("sat 485 RefPending", RefPending, 4);
    checkOutput("sat 485 RefOverrun", RefOverrun, 0);
    stepEdges(120);
    checkOutput("sat 605 RefPending", RefPending, 4);
    checkOutput("sat 605 RefOverrun", RefOverrun, 1);
    applyStimulus(0, 1, 0, 1, 1, 1, '0);
    stepEdges(40);
    checkOutput("sat drained RefPending", RefPending, 0);
    checkOutput("sat drained RefOverrun", RefOverrun, 1);

    // Asynchronous reset in CAS.
    doReset();
    applyStimulus(1, 0, 1, 1, 0, 0, {10'h123, 10'h321});
    stepEdges(3);
    checkOutput("areset pre nCAS", nCAS, 0);
    #2;
    nRESET = 1'b0;
    #1;
    checkOutput("areset nRAS", nRAS, 1);
    checkOutput("areset nCAS", nCAS, 1);
    checkOutput("areset Ready", Ready, 0);
    @(negedge CLK);
    #2;
    nRESET = 1'b1;
    stepEdges(1);
    checkOutput("areset restart nRAS", nRAS, 0);
    checkOutput("areset restart nCAS", nCAS, 1);
    checkOutput("areset restart RA", RA, 10'h123);
    stepEdges(2);
    checkOutput("areset restart col nCAS", nCAS, 0);
    applyStimulus(0, 1, 0, 1, 1, 1, '0);
    stepEdges(5);

    // Randomized bus traffic against the model.
    doReset();
    for (int t = 0; t < 160; t++) begin
      gap = $urandom_range(0, 4);
      applyStimulus(0, 1, 1'($urandom_range(0, 1)), 1, 1, 1, 20'($urandom));
      stepEdges(gap + 1);
      len = ($urandom_range(0, 15) == 0) ? $urandom_range(100, 400) : $urandom_range(1, 12);
      applyStimulus(1, 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 20'($urandom));
      stepEdges(len);
    end
    applyStimulus(0, 1, 0, 1, 1, 1, '0);
    stepEdges(10);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
